// File: rtl/conv_buf_pkg.sv
// +----------------------------------------------------------------------------+
// | Package    : conv_buf_pkg                                                  |
// | Description: Shared sizes and types for the conv ping-pong feature buffer. |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

package conv_buf_pkg;
    localparam int CONV_DW = 192;
    localparam int CONV_DP = 32;
    localparam int CONV_LW = 8;

    typedef logic       bank_idx_t;
    typedef logic [1:0] fill_cnt_t;

    localparam fill_cnt_t FILL_EMPTY = 2'd0;
    localparam fill_cnt_t FILL_FULL  = 2'd2;
endpackage

`default_nettype wire

// File: rtl/conv_sram_bank.sv
// +----------------------------------------------------------------------------+
// | Module     : conv_sram_bank                                                |
// | Description: One DP x DW bank with lane-masked write and registered read.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_sram_bank #(
    parameter  int DW           = 192,
    parameter  int DP           = 32,
    parameter  int LW           = 8,
    parameter  int FORCE_X2ZERO = 1,
    localparam int AW           = $clog2(DP),
    localparam int MW           = DW / LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          rd_en,
    input  logic          rd_zero,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DP];
    logic [DW-1:0] rd_word;
    logic [DW-1:0] rd_data_d;
    logic [DW-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < MW; i++) begin
                if (wr_mask[i]) begin
                    mem[wr_addr][LW*i +: LW] <= wr_data[LW*i +: LW];
                end
            end
        end
    end

    always_comb begin
        rd_word = mem[rd_addr];
`ifndef SYNTHESIS
        // Never-written words read back as zero instead of propagating X.
        if (FORCE_X2ZERO != 0) begin
            for (int b = 0; b < DW; b++) begin
                rd_word[b] = (mem[rd_addr][b] === 1'b1);
            end
        end
`endif
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = rd_zero ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= '0;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;
endmodule

`default_nettype wire

// File: rtl/conv_pingpong_sram.sv
// +----------------------------------------------------------------------------+
// | Module     : conv_pingpong_sram                                            |
// | Description: Ping-pong feature-map SRAM with bank handshake and err flag.  |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module conv_pingpong_sram
    import conv_buf_pkg::*;
#(
    parameter  int DW           = CONV_DW,
    parameter  int DP           = CONV_DP,
    parameter  int LW           = CONV_LW,
    parameter  int FORCE_X2ZERO = 1,
    localparam int AW           = $clog2(DP),
    localparam int MW           = DW / LW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [MW-1:0] wr_mask,
    input  logic          wr_last,
    input  logic          rd_req_valid,
    output logic          rd_req_ready,
    input  logic [AW-1:0] rd_addr,
    input  logic          rd_done,
    output logic          rd_data_valid,
    output logic [DW-1:0] rd_data,
    output logic          wr_bank,
    output logic          rd_bank,
    output logic [1:0]    fill_cnt,
    output logic          err
);
    bank_idx_t     wr_bank_d, wr_bank_q;
    bank_idx_t     rd_bank_d, rd_bank_q;
    bank_idx_t     rd_sel_d, rd_sel_q;
    fill_cnt_t     fill_d, fill_q;
    logic          rd_valid_d, rd_valid_q;
    logic          err_d, err_q;

    logic          wr_addr_ok, rd_addr_ok;
    logic          wr_acc, rd_acc, wr_fin, rel;
    logic [DW-1:0] bank_rd [2];

    if (DP == (1 << AW)) begin : g_pow2_range
        assign wr_addr_ok = 1'b1;
        assign rd_addr_ok = 1'b1;
    end else begin : g_partial_range
        assign wr_addr_ok = (32'(wr_addr) < DP);
        assign rd_addr_ok = (32'(rd_addr) < DP);
    end

    assign wr_ready     = (fill_q != FILL_FULL);
    assign rd_req_ready = (fill_q != FILL_EMPTY);
    assign wr_acc       = wr_valid & wr_ready;
    assign rd_acc       = rd_req_valid & rd_req_ready;
    assign wr_fin       = wr_acc & wr_last;
    assign rel          = rd_done & (fill_q != FILL_EMPTY);

    always_comb begin
        wr_bank_d  = wr_fin ? ~wr_bank_q : wr_bank_q;
        rd_bank_d  = rel ? ~rd_bank_q : rd_bank_q;
        fill_d     = fill_q + fill_cnt_t'(wr_fin) - fill_cnt_t'(rel);
        rd_valid_d = rd_acc;
        // Reads take the pre-toggle bank so a same-cycle release still delivers data.
        rd_sel_d   = rd_acc ? rd_bank_q : rd_sel_q;
        err_d      = err_q
                   | (wr_valid & ~wr_ready)
                   | (rd_req_valid & ~rd_req_ready)
                   | (rd_done & (fill_q == FILL_EMPTY))
                   | (wr_acc & ~wr_addr_ok)
                   | (rd_acc & ~rd_addr_ok);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_bank_q  <= 1'b0;
            rd_bank_q  <= 1'b0;
            rd_sel_q   <= 1'b0;
            fill_q     <= FILL_EMPTY;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_bank_q  <= wr_bank_d;
            rd_bank_q  <= rd_bank_d;
            rd_sel_q   <= rd_sel_d;
            fill_q     <= fill_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        conv_sram_bank #(
            .DW           (DW),
            .DP           (DP),
            .LW           (LW),
            .FORCE_X2ZERO (FORCE_X2ZERO)
        ) u_bank (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_acc & wr_addr_ok & (wr_bank_q == bank_idx_t'(b))),
            .wr_addr (wr_addr),
            .wr_data (wr_data),
            .wr_mask (wr_mask),
            .rd_en   (rd_acc & (rd_bank_q == bank_idx_t'(b))),
            .rd_zero (~rd_addr_ok),
            .rd_addr (rd_addr),
            .rd_data (bank_rd[b])
        );
    end

    assign rd_data       = bank_rd[rd_sel_q];
    assign rd_data_valid = rd_valid_q;
    assign wr_bank       = wr_bank_q;
    assign rd_bank       = rd_bank_q;
    assign fill_cnt      = fill_q;
    assign err           = err_q;
endmodule

`default_nettype wire

// File: tb/tb_conv_pingpong_sram.sv
// +----------------------------------------------------------------------------+
// | Module     : tb_conv_pingpong_sram                                         |
// | Description: Directed self-checking bench for conv_pingpong_sram.          |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_conv_pingpong_sram;
    localparam int DW = 192;
    localparam int AW = 5;
    localparam int MW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_valid, wr_ready, wr_last;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [MW-1:0] wr_mask;
    logic          rd_req_valid, rd_req_ready, rd_done;
    logic [AW-1:0] rd_addr;
    logic          rd_data_valid;
    logic [DW-1:0] rd_data;
    logic          wr_bank, rd_bank, err;
    logic [1:0]    fill_cnt;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    conv_pingpong_sram dut (
        .clk           (clk),
        .rst           (rst),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .wr_mask       (wr_mask),
        .wr_last       (wr_last),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_addr       (rd_addr),
        .rd_done       (rd_done),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_bank       (wr_bank),
        .rd_bank       (rd_bank),
        .fill_cnt      (fill_cnt),
        .err           (err)
    );

    task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_valid = 0; wr_last = 0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_req_valid = 0; rd_addr = '0; rd_done = 0;
    endtask

    task automatic do_write(input int a, input logic [DW-1:0] d, input logic [MW-1:0] m,
                            input logic last);
        wr_valid = 1; wr_addr = AW'(a); wr_data = d; wr_mask = m; wr_last = last;
        tick();
        wr_valid = 0; wr_last = 0;
    endtask

    task automatic do_read(input int a);
        rd_req_valid = 1; rd_addr = AW'(a);
        tick();
        rd_req_valid = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        #2;
        rst = 0;
        tick();
    endtask

    initial begin
        logic [DW-1:0] ones;
        logic [DW-1:0] lowzero;
        ones    = '1;
        lowzero = {{23{8'hFF}}, 8'h00};
        idle();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        rst = 0;
        tick();

        // Test 1: five writes (last completes bank0), a read, then async reset
        for (int i = 0; i < 5; i++) do_write(i, DW'(i + 10), '1, i == 4);
        do_read(2);
        check("pre_rst_fill", DW'(fill_cnt), DW'(1));
        check("pre_rst_data", rd_data, DW'(12));
        rst = 1;
        #2;
        check("rst_wr_bank", DW'(wr_bank), DW'(0));
        check("rst_rd_bank", DW'(rd_bank), DW'(0));
        check("rst_fill", DW'(fill_cnt), DW'(0));
        check("rst_rdv", DW'(rd_data_valid), DW'(0));
        check("rst_rd_data", rd_data, DW'(0));
        check("rst_err", DW'(err), DW'(0));
        check("rst_wr_ready", DW'(wr_ready), DW'(1));
        check("rst_rd_ready", DW'(rd_req_ready), DW'(0));
        rst = 0;
        tick();

        // Test 2: fill bank0 with addr*3, read addr 7
        for (int i = 0; i < 32; i++) do_write(i, DW'(i * 3), '1, i == 31);
        check("t2_fill", DW'(fill_cnt), DW'(1));
        check("t2_wr_bank", DW'(wr_bank), DW'(1));
        do_read(7);
        check("t2_rdv", DW'(rd_data_valid), DW'(1));
        check("t2_rd_data", rd_data, DW'(21));
        tick();
        check("t2_rdv_drop", DW'(rd_data_valid), DW'(0));
        check("t2_rd_hold", rd_data, DW'(21));

        // Test 3/4: lane-masked write into bank1, then both banks full
        do_write(0, ones, '1, 1'b0);
        do_write(0, '0, MW'(1), 1'b0);
        do_write(31, DW'(5), '1, 1'b1);
        check("t4_fill", DW'(fill_cnt), DW'(2));
        check("t4_wr_ready", DW'(wr_ready), DW'(0));
        check("t4_err_pre", DW'(err), DW'(0));
        do_write(7, DW'(16'hDEAD), '1, 1'b0);
        check("t4_err", DW'(err), DW'(1));
        check("t4_fill_hold", DW'(fill_cnt), DW'(2));
        do_read(7);
        check("t4_bank0_keep", rd_data, DW'(21));
        rd_done = 1;
        tick();
        rd_done = 0;
        check("t4_rel_rd_bank", DW'(rd_bank), DW'(1));
        check("t4_rel_fill", DW'(fill_cnt), DW'(1));
        do_read(0);
        check("t3_lane_mask", rd_data, lowzero);

        // Test 5: simultaneous wr_last, rd_done and read (pre-toggle bank)
        wr_valid = 1; wr_addr = 5'd3; wr_data = DW'(99); wr_mask = '1; wr_last = 1;
        rd_done = 1; rd_req_valid = 1; rd_addr = 5'd31;
        tick();
        idle();
        check("t5_fill", DW'(fill_cnt), DW'(1));
        check("t5_wr_bank", DW'(wr_bank), DW'(1));
        check("t5_rd_bank", DW'(rd_bank), DW'(0));
        check("t5_rdv", DW'(rd_data_valid), DW'(1));
        check("t5_pretoggle_data", rd_data, DW'(5));
        do_read(3);
        check("t5_new_word", rd_data, DW'(99));
        do_read(8);
        check("t5_old_word", rd_data, DW'(24));

        // Test 6: empty buffer, read request and release both rejected
        do_reset();
        rd_req_valid = 1; rd_done = 1;
        tick();
        idle();
        check("t6_rdv", DW'(rd_data_valid), DW'(0));
        check("t6_err", DW'(err), DW'(1));
        check("t6_fill", DW'(fill_cnt), DW'(0));
        check("t6_rd_bank", DW'(rd_bank), DW'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

`default_nettype wire
